ripple_carry_adder_4b: RTL and testbench



---
 rtl/ripple_carry_adder_4b_pkg.sv | 7 +
 rtl/ripple_carry_adder_4b_full_adder.sv | 21 ++
 rtl/ripple_carry_adder_4b.sv | 76 +++++++
 tb/tb_ripple_carry_adder_4b.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ripple_carry_adder_4b_pkg.sv
// Shared constants for the registered ripple-carry adder.
package ripple_carry_adder_4b_pkg;

  // Operand and sum width used when the top is instantiated without overrides.
  localparam int unsigned ADDER_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/ripple_carry_adder_4b_full_adder.sv
// One-bit combinational full-adder cell; the building block of the carry chain.
module full_adder
  import ripple_carry_adder_4b_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic prop;

  // Sum and carry from propagate/generate terms.
  always_comb begin
    prop = a ^ b;
    s    = prop ^ cin;
    cout = (a & b) | (cin & prop);
  end

endmodule

// File: rtl/ripple_carry_adder_4b.sv
// Registered WIDTH-bit ripple-carry adder: {cout, s} <= a + b + cin when in_valid.
module ripple_carry_adder_4b
  import ripple_carry_adder_4b_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum;
  logic             carry_out;

  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             valid_q, valid_d;

  // Each cell keeps its own carry nets so the chain is a plain bit-to-bit ripple
  // with no vector that is both read and written along the chain.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic c_in;
    logic c_out;

    if (i == 0) begin : g_first
      assign c_in = cin;
    end else begin : g_next
      assign c_in = g_cell[i-1].c_out;
    end

    full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (c_in),
      .s   (sum[i]),
      .cout(c_out)
    );
  end

  assign carry_out = g_cell[WIDTH-1].c_out;

  // Capture the new result only on valid operands; otherwise hold.
  always_comb begin
    s_d     = s_q;
    cout_d  = cout_q;
    valid_d = in_valid;
    if (in_valid) begin
      s_d    = sum;
      cout_d = carry_out;
    end
  end

  // Output registers with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q     <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_ripple_carry_adder_4b.sv
// Self-checking bench for ripple_carry_adder_4b at WIDTH=4 and WIDTH=8.
module tb_ripple_carry_adder_4b;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a, b;
  logic       cin;
  logic [3:0] s;
  logic       cout, out_valid;

  logic       in_valid8;
  logic [7:0] a8, b8;
  logic       cin8;
  logic [7:0] s8;
  logic       cout8, out_valid8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ripple_carry_adder_4b #(.WIDTH(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .s        (s),
    .cout     (cout),
    .out_valid(out_valid)
  );

  ripple_carry_adder_4b #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid8),
    .a        (a8),
    .b        (b8),
    .cin      (cin8),
    .s        (s8),
    .cout     (cout8),
    .out_valid(out_valid8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] exp_s;
    logic       exp_cout;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive the 4-bit DUT, then advance one edge and settle 1 time unit past it.
  task automatic step(input logic [3:0] ai, input logic [3:0] bi, input logic ci, input logic vi);
    a        = ai;
    b        = bi;
    cin      = ci;
    in_valid = vi;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [3:0] es, input logic ec,
                         input logic ev);
    chk({name, ".s"}, 32'(s), 32'(es));
    chk({name, ".cout"}, 32'(cout), 32'(ec));
    chk({name, ".out_valid"}, 32'(out_valid), 32'(ev));
  endtask

  initial begin
    vec_t       vecs[$];
    logic [4:0] ref5;
    logic [3:0] m_s;
    logic       m_cout;
    logic [3:0] ra, rb;
    logic       rc, rv;

    rst_n     = 1'b0;
    a8        = '0;
    b8        = '0;
    cin8      = 1'b0;
    in_valid8 = 1'b0;

    // Reset dominates valid operands.
    step(4'hF, 4'hF, 1'b0, 1'b1);
    chk_out("reset_c1", 4'h0, 1'b0, 1'b0);
    step(4'hF, 4'hF, 1'b0, 1'b1);
    chk_out("reset_c2", 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(4'hF, 4'hF, 1'b0, 1'b1);
    chk_out("post_reset", 4'hE, 1'b1, 1'b1);

    // Table of hand-derived vectors.
    vecs.push_back('{4'h7, 4'h7, 1'b0, 4'hE, 1'b0});
    vecs.push_back('{4'h8, 4'h8, 1'b0, 4'h0, 1'b1});
    vecs.push_back('{4'hF, 4'hF, 1'b0, 4'hE, 1'b1});
    vecs.push_back('{4'hF, 4'h0, 1'b1, 4'h0, 1'b1});
    vecs.push_back('{4'h0, 4'h0, 1'b1, 4'h1, 1'b0});
    vecs.push_back('{4'h5, 4'hA, 1'b0, 4'hF, 1'b0});
    vecs.push_back('{4'h5, 4'hA, 1'b1, 4'h0, 1'b1});
    vecs.push_back('{4'h3, 4'h4, 1'b0, 4'h7, 1'b0});
    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1);
      chk_out($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_cout, 1'b1);
    end

    // Doubling sweep a=b=0..15.
    for (int i = 0; i < 16; i++) begin
      ref5 = 5'(2 * i);
      step(4'(i), 4'(i), 1'b0, 1'b1);
      chk_out($sformatf("double%0d", i), ref5[3:0], ref5[4], 1'b1);
    end

    // Hold: 3+4 captured, then 9+9 without valid must not update.
    step(4'h3, 4'h4, 1'b0, 1'b1);
    chk_out("hold_load", 4'h7, 1'b0, 1'b1);
    step(4'h9, 4'h9, 1'b0, 1'b0);
    chk_out("hold_keep", 4'h7, 1'b0, 1'b0);
    step(4'h9, 4'h9, 1'b1, 1'b0);
    chk_out("hold_keep2", 4'h7, 1'b0, 1'b0);

    // Reset mid-stream discards the in-flight result.
    step(4'hC, 4'h9, 1'b1, 1'b1);
    chk_out("stream_pre", 4'h6, 1'b1, 1'b1);
    rst_n = 1'b0;
    step(4'hA, 4'hA, 1'b1, 1'b1);
    chk_out("stream_rst", 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(4'h1, 4'h2, 1'b0, 1'b1);
    chk_out("stream_resume", 4'h3, 1'b0, 1'b1);

    // Exhaustive sweep of all {a, b, cin}.
    for (int i = 0; i < 512; i++) begin
      ra   = 4'(i >> 5);
      rb   = 4'(i >> 1);
      rc   = 1'(i);
      ref5 = 5'(int'(ra) + int'(rb) + int'(rc));
      step(ra, rb, rc, 1'b1);
      chk_out($sformatf("exh_%0h_%0h_%0d", ra, rb, rc), ref5[3:0], ref5[4], 1'b1);
    end

    // Random stimulus with random valid against an arithmetic reference.
    m_s    = s;
    m_cout = cout;
    for (int i = 0; i < 200; i++) begin
      ra = 4'($urandom_range(15));
      rb = 4'($urandom_range(15));
      rc = 1'($urandom_range(1));
      rv = 1'($urandom_range(1));
      if (rv) begin
        ref5   = 5'(int'(ra) + int'(rb) + int'(rc));
        m_s    = ref5[3:0];
        m_cout = ref5[4];
      end
      step(ra, rb, rc, rv);
      chk_out($sformatf("rand%0d", i), m_s, m_cout, rv);
    end

    // WIDTH=8 instance.
    a8        = 8'hFF;
    b8        = 8'h01;
    cin8      = 1'b0;
    in_valid8 = 1'b1;
    step(4'h0, 4'h0, 1'b0, 1'b0);
    chk("w8.s", 32'(s8), 32'h00);
    chk("w8.cout", 32'(cout8), 32'h1);
    chk("w8.out_valid", 32'(out_valid8), 32'h1);
    a8   = 8'h80;
    b8   = 8'h7F;
    cin8 = 1'b1;
    step(4'h0, 4'h0, 1'b0, 1'b0);
    chk("w8_ripple.s", 32'(s8), 32'h00);
    chk("w8_ripple.cout", 32'(cout8), 32'h1);
    a8        = 8'h12;
    b8        = 8'h34;
    cin8      = 1'b0;
    in_valid8 = 1'b0;
    step(4'h0, 4'h0, 1'b0, 1'b0);
    chk("w8_hold.s", 32'(s8), 32'h00);
    chk("w8_hold.out_valid", 32'(out_valid8), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
